sisc_fetch: RTL and testbench
=============================

// Module: sisc_fetch
// PURPOSE
//   Instruction fetch stage directly upstream of the sisc core; produces its 32-bit ir input.
//   Holds the program counter and issues word reads to instruction memory with a req/ack handshake.
//   Presents each fetched instruction to the core with a valid/ready handshake.
//   Accepts branch redirects and a halt request from the core's control unit.
// PARAMETERS
//   ADDR_W    16   instruction memory word-address width; PC width
//   IR_W      32   instruction width; must match sisc ir
//   RESET_PC  0    PC value loaded on reset
// PORTS
//   clk          in   1       clock; all state updates on rising edge
//   rst_f        in   1       reset; asynchronous, active-high
//   imem_req     out  1       memory read request
//   imem_addr    out  ADDR_W  word address of request
//   imem_ack     in   1       memory accepted request; imem_rdata valid in the same cycle
//   imem_rdata   in   IR_W    instruction word returned by memory
//   ir           out  IR_W    instruction to the core
//   ir_pc        out  ADDR_W  address ir was fetched from
//   ir_valid     out  1       ir/ir_pc hold a valid instruction
//   ir_ready     in   1       core consumes ir this cycle
//   redirect     in   1       branch taken; restart fetch at redirect_pc
//   redirect_pc  in   ADDR_W  branch target word address
//   halt         in   1       stop fetching permanently (until reset)
//   halted       out  1       fetch stopped, no request outstanding
// BEHAVIOUR
//   Reset (async): pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, imem_req=0, halted=0, state=IDLE.
//   States: IDLE, REQ, DROP, HOLD, HALT.
//   IDLE : one cycle after reset release -> REQ.
//   REQ  : imem_req=1, imem_addr=pc; addr held stable until imem_ack (no request withdrawal).
//     ack, no redirect: ir<=imem_rdata, ir_pc<=pc, ir_valid<=1, pc<=pc+1 -> HOLD.
//     redirect, no ack: pc<=redirect_pc -> DROP (request stays up at old addr).
//     redirect with ack same cycle: data discarded, pc<=redirect_pc -> REQ.
//   DROP : imem_req=1 at old addr; on ack discard data -> REQ (new pc).
//     A further redirect in DROP overwrites pc; latest redirect wins.
//   HOLD : imem_req=0, ir_valid=1, ir/ir_pc stable.
//     ir_ready, no redirect: ir_valid<=0 -> REQ. Issue-to-issue = 2 cycles min.
//     redirect (with or without ir_ready): ir_valid<=0, pc<=redirect_pc -> REQ.
//   Priority per cycle: rst_f > redirect > halt > ack/ready.
//   halt: sampled in any state; if no request outstanding (IDLE/HOLD) -> HALT next cycle.
//     In REQ/DROP the outstanding request completes first; data discarded -> HALT.
//     Entering HALT clears ir_valid. HALT: imem_req=0, halted=1; leaves only on reset.
//   ir_valid never rises in the same cycle a redirect is accepted.
//   pc+1 wraps modulo 2**ADDR_W (max address -> 0); no error flag.
//   Minimum latency: imem_req rise to ir_valid = 1 cycle when ack is same-cycle.
//   Reset asserted mid-request: imem_req drops immediately (async); late ack after release ignored.
// TESTING
//   Reset release, imem_ack tied 1, ir_ready tied 1 -> addrs 0,1,2,... one issue per 2 cycles; ir=mem[n].
//   ir_ready low 5 cycles while ir_valid -> ir/ir_pc constant, imem_req=0, pc unchanged.
//   Ack delayed 3 cycles at addr 4, redirect to 0x20 in 2nd wait cycle -> addr 4 held until ack,
//     data discarded, next req addr 0x20, ir_pc=0x20.
//   Redirect in HOLD with ir_ready=1 at ir_pc=7, target 0x10 -> ir_valid drops, next req addr 0x10.
//   RESET_PC=0xFFFF, ADDR_W=16 -> fetch 0xFFFF then 0x0000.
//   halt during REQ with ack 2 cycles later -> data dropped, halted=1, imem_req=0 thereafter;
//     rst_f pulse -> fetch resumes at RESET_PC.

Source files
------------

// File: rtl/sisc_fetch.sv
// -----------------------------------------------------------------------------
// sisc_fetch
//   Instruction fetch stage feeding the sisc core's 32-bit ir input.
//   Holds the program counter, issues word reads to instruction memory over a
//   req/ack handshake and presents each fetched word to the core over a
//   valid/ready handshake. Accepts branch redirects and a permanent halt.
//
// Ports
//   clk          in   clock, rising edge
//   rst_f        in   asynchronous active-high reset
//   imem_req     out  memory read request (REQ/DROP states)
//   imem_addr    out  word address of the outstanding request
//   imem_ack     in   memory accepted request; imem_rdata valid same cycle
//   imem_rdata   in   instruction word from memory
//   ir           out  instruction to the core
//   ir_pc        out  address ir was fetched from
//   ir_valid     out  ir/ir_pc hold a valid instruction
//   ir_ready     in   core consumes ir this cycle
//   redirect     in   branch taken; restart fetch at redirect_pc
//   redirect_pc  in   branch target word address
//   halt         in   stop fetching until reset
//   halted       out  fetch stopped, nothing outstanding
// -----------------------------------------------------------------------------
module sisc_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                IR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [IR_W-1:0]   imem_rdata,
    output logic [IR_W-1:0]   ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        DROP = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n;
    logic [ADDR_W-1:0]   addr_q;
    logic                valid_n;
    logic                load_ir;
    logic                halt_pend, halt_pend_n;
    logic                halt_eff;
    logic                req_active;

    // Request is a pure function of state so an async reset drops it at once.
    assign req_active = (state == REQ) || (state == DROP);
    assign imem_req   = req_active;
    assign imem_addr  = addr_q;
    assign halted     = (state == HALT);

    // A halt seen while a request is outstanding is remembered until the
    // request completes; redirect outranks halt in the cycle they coincide.
    assign halt_eff = halt_pend | (halt & ~redirect);

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_n = state;
        pc_n    = pc;
        valid_n = ir_valid;
        load_ir = 1'b0;

        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_n    = redirect_pc;
                    state_n = REQ;
                end else if (halt) begin
                    state_n = HALT;
                end else begin
                    state_n = REQ;
                end
            end

            REQ: begin
                if (redirect)
                    pc_n = redirect_pc;
                if (imem_ack) begin
                    if (halt_eff) begin
                        state_n = HALT;
                    end else if (redirect) begin
                        state_n = REQ;           // data belongs to the old path
                    end else begin
                        load_ir = 1'b1;
                        valid_n = 1'b1;
                        pc_n    = pc + ADDR_W'(1);
                        state_n = HOLD;
                    end
                end else if (redirect) begin
                    state_n = DROP;              // request stays up at old addr
                end
            end

            DROP: begin
                if (redirect)
                    pc_n = redirect_pc;          // latest redirect wins
                if (imem_ack)
                    state_n = halt_eff ? HALT : REQ;
            end

            HOLD: begin
                if (redirect) begin
                    valid_n = 1'b0;
                    pc_n    = redirect_pc;
                    state_n = REQ;
                end else if (halt) begin
                    valid_n = 1'b0;
                    state_n = HALT;
                end else if (ir_ready) begin
                    valid_n = 1'b0;
                    state_n = REQ;
                end
            end

            HALT: begin
                valid_n = 1'b0;
            end

            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase

        halt_pend_n = ((state_n == REQ) || (state_n == DROP)) ? halt_eff : 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen before the edge.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            addr_q    <= RESET_PC;
            ir        <= '0;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ir_valid  <= valid_n;
            halt_pend <= halt_pend_n;
            // Address is frozen while a request waits for its ack; otherwise
            // it follows the pc so the next request issues at the right place.
            if (!(req_active && !imem_ack))
                addr_q <= pc_n;
            if (load_ir) begin
                ir    <= imem_rdata;
                ir_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_sisc_fetch.sv
// -----------------------------------------------------------------------------
// tb_sisc_fetch
//   Directed bench for sisc_fetch. Instance a uses RESET_PC=0 and a controllable
//   memory; instance b uses RESET_PC=0xFFFF with memory and core always ready,
//   to show the pc wrapping from the top address to zero.
// -----------------------------------------------------------------------------
module tb_sisc_fetch;

    localparam int ADDR_W = 16;
    localparam int IR_W   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory contents: a recognisable function of the word address.
    function automatic logic [IR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    // ---------------- instance a ----------------
    logic              rst_a;
    logic              ack_auto, ack_man;
    logic              a_req, a_ack, a_valid, a_ready, a_redirect, a_halt, a_halted;
    logic [ADDR_W-1:0] a_addr, a_ir_pc, a_rpc;
    logic [IR_W-1:0]   a_rdata, a_ir;

    assign a_ack   = ack_auto ? a_req : ack_man;
    assign a_rdata = mem_word(a_addr);

    sisc_fetch #(.ADDR_W(ADDR_W), .IR_W(IR_W), .RESET_PC(16'h0000)) dut_a (
        .clk(clk), .rst_f(rst_a),
        .imem_req(a_req), .imem_addr(a_addr), .imem_ack(a_ack), .imem_rdata(a_rdata),
        .ir(a_ir), .ir_pc(a_ir_pc), .ir_valid(a_valid), .ir_ready(a_ready),
        .redirect(a_redirect), .redirect_pc(a_rpc), .halt(a_halt), .halted(a_halted)
    );

    // ---------------- instance b ----------------
    logic              rst_b;
    logic              b_req, b_valid, b_halted;
    logic [ADDR_W-1:0] b_addr, b_ir_pc;
    logic [IR_W-1:0]   b_rdata, b_ir;

    assign b_rdata = mem_word(b_addr);

    sisc_fetch #(.ADDR_W(ADDR_W), .IR_W(IR_W), .RESET_PC(16'hFFFF)) dut_b (
        .clk(clk), .rst_f(rst_b),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_req), .imem_rdata(b_rdata),
        .ir(b_ir), .ir_pc(b_ir_pc), .ir_valid(b_valid), .ir_ready(1'b1),
        .redirect(1'b0), .redirect_pc(16'h0000), .halt(1'b0), .halted(b_halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [ADDR_W-1:0] b_exp;

        rst_a = 1'b1; rst_b = 1'b1;
        ack_auto = 1'b1; ack_man = 1'b0;
        a_ready = 1'b1; a_redirect = 1'b0; a_rpc = '0; a_halt = 1'b0;

        // Reset state
        #1;
        check("rst_req",    32'(a_req),    32'd0);
        check("rst_valid",  32'(a_valid),  32'd0);
        check("rst_ir",     a_ir,          32'd0);
        check("rst_ir_pc",  32'(a_ir_pc),  32'd0);
        check("rst_halted", 32'(a_halted), 32'd0);
        check("rst_b_req",  32'(b_req),    32'd0);

        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // IDLE -> REQ one cycle after release
        tick();
        check("first_req",  32'(a_req),  32'd1);
        check("first_addr", 32'(a_addr), 32'd0);
        check("b_first_addr", 32'(b_addr), 32'h0000_FFFF);

        // Streaming with ack and ready tied high: one issue per 2 cycles
        for (int n = 0; n < 3; n++) begin
            b_exp = 16'hFFFF + 16'(n);
            tick();
            check("stream_valid", 32'(a_valid), 32'd1);
            check("stream_ir_pc", 32'(a_ir_pc), 32'(n));
            check("stream_ir",    a_ir,         mem_word(16'(n)));
            check("stream_req_lo", 32'(a_req),  32'd0);
            if (n < 2) begin
                check("b_ir_pc", 32'(b_ir_pc), 32'(b_exp));
                check("b_ir",    b_ir,         mem_word(b_exp));
            end
            tick();
            check("stream_req",  32'(a_req),  32'd1);
            check("stream_addr", 32'(a_addr), 32'(n + 1));
            if (n == 0)
                check("b_wrap_addr", 32'(b_addr), 32'd0);
        end

        // Core stalls for 5 cycles while ir_valid
        a_ready = 1'b0;
        tick();
        check("stall_enter_pc", 32'(a_ir_pc), 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(a_valid), 32'd1);
            check("stall_ir_pc", 32'(a_ir_pc), 32'd3);
            check("stall_ir",    a_ir,         mem_word(16'd3));
            check("stall_req",   32'(a_req),   32'd0);
        end
        a_ready = 1'b1;
        tick();
        check("after_stall_addr", 32'(a_addr), 32'd4);
        check("after_stall_req",  32'(a_req),  32'd1);

        // Ack delayed 3 cycles at addr 4, redirect to 0x20 in 2nd wait cycle
        ack_auto = 1'b0; ack_man = 1'b0;
        tick();
        check("wait1_addr", 32'(a_addr), 32'd4);
        a_redirect = 1'b1; a_rpc = 16'h0020;
        tick();
        a_redirect = 1'b0;
        check("wait2_addr", 32'(a_addr), 32'd4);
        check("wait2_req",  32'(a_req),  32'd1);
        tick();
        check("wait3_addr",  32'(a_addr),  32'd4);
        check("wait3_valid", 32'(a_valid), 32'd0);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0; ack_auto = 1'b1;
        check("drop_next_addr",  32'(a_addr),  32'h20);
        check("drop_next_req",   32'(a_req),   32'd1);
        check("drop_discard_valid", 32'(a_valid), 32'd0);
        tick();
        check("drop_ir_pc", 32'(a_ir_pc), 32'h20);
        check("drop_ir",    a_ir,         mem_word(16'h20));

        // Redirect in HOLD to reach address 7
        a_redirect = 1'b1; a_rpc = 16'h0007;
        tick();
        a_redirect = 1'b0;
        check("hold_redir7_valid", 32'(a_valid), 32'd0);
        check("hold_redir7_addr",  32'(a_addr),  32'd7);
        tick();
        check("at7_ir_pc", 32'(a_ir_pc), 32'd7);

        // Redirect in HOLD with ir_ready=1 at ir_pc=7, target 0x10
        a_redirect = 1'b1; a_rpc = 16'h0010;
        tick();
        a_redirect = 1'b0;
        check("hold_redir_valid", 32'(a_valid), 32'd0);
        check("hold_redir_addr",  32'(a_addr),  32'h10);
        check("hold_redir_req",   32'(a_req),   32'd1);
        tick();
        check("at10_ir_pc", 32'(a_ir_pc), 32'h10);
        check("at10_valid", 32'(a_valid), 32'd1);

        // Redirect and ack in the same REQ cycle: data discarded, restart
        tick();
        check("req11_addr", 32'(a_addr), 32'h11);
        a_redirect = 1'b1; a_rpc = 16'h0030;
        tick();
        a_redirect = 1'b0;
        check("same_cyc_valid", 32'(a_valid), 32'd0);
        check("same_cyc_addr",  32'(a_addr),  32'h30);
        check("same_cyc_req",   32'(a_req),   32'd1);
        tick();
        check("at30_ir_pc", 32'(a_ir_pc), 32'h30);

        // Halt during REQ, ack 2 cycles later
        tick();
        check("req31_addr", 32'(a_addr), 32'h31);
        ack_auto = 1'b0; ack_man = 1'b0;
        a_halt = 1'b1;
        tick();
        a_halt = 1'b0;
        check("halt_wait_req",    32'(a_req),    32'd1);
        check("halt_wait_halted", 32'(a_halted), 32'd0);
        tick();
        check("halt_wait2_req", 32'(a_req), 32'd1);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0; ack_auto = 1'b1;
        check("halted",        32'(a_halted), 32'd1);
        check("halted_req",    32'(a_req),    32'd0);
        check("halted_valid",  32'(a_valid),  32'd0);
        check("halted_ir_pc",  32'(a_ir_pc),  32'h30);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_stays",     32'(a_halted), 32'd1);
            check("halt_stays_req", 32'(a_req),    32'd0);
        end

        // Reset pulse restarts fetch at RESET_PC
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("rst_pulse_halted", 32'(a_halted), 32'd0);
        rst_a = 1'b0;
        tick();
        check("resume_req",  32'(a_req),  32'd1);
        check("resume_addr", 32'(a_addr), 32'd0);
        tick();
        check("resume_ir_pc", 32'(a_ir_pc), 32'd0);
        check("resume_valid", 32'(a_valid), 32'd1);
        tick();
        check("resume_addr1", 32'(a_addr), 32'd1);

        // Reset mid-request: req drops at once; ack after release is ignored
        #1;
        rst_a = 1'b1;
        #1;
        check("midreq_rst_req", 32'(a_req), 32'd0);
        ack_auto = 1'b0; ack_man = 1'b1;
        rst_a = 1'b0;
        tick();
        check("late_ack_valid", 32'(a_valid), 32'd0);
        check("late_ack_addr",  32'(a_addr),  32'd0);
        check("late_ack_req",   32'(a_req),   32'd1);
        tick();
        check("late_ack_ir_pc", 32'(a_ir_pc), 32'd0);
        check("late_ack_vld2",  32'(a_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
